debounce_fsm: RTL and testbench
===============================

# debounce_fsm

Debounces and qualifies a raw, possibly asynchronous level input (push-button, external strobe) before it reaches the rising-edge detector FSM. The block sits directly upstream of the edge detector. Its `signal_out` is a clean, glitch-free level that drives the edge detector's `signal_in`. A level change is committed only after the sampled input has held the new value for `STABLE_CYCLES` consecutive clock edges.

## Interface
- `STABLE_CYCLES`, default 16: consecutive agreeing samples required to commit a level change; legal range 2 .. 2^`CNT_W`-1.
- `CNT_W`, default 5: stability counter width.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset. Asynchronous, active-low: one clock, and reset is asynchronous and active-low.
- `signal_in`  input  1  raw level, may be asynchronous to `clk`.
- `signal_out`  output  1  debounced level, registered.
- `busy`  output  1  high while a candidate transition is being qualified (state WAIT_HIGH or WAIT_LOW); decoded from the state register only.
- `glitch`  output  1  registered one-cycle pulse when a candidate transition is aborted.

## Operation
- `s` is the sampled input: the output of the synchronizer when it is compiled in (see Configuration), otherwise `signal_in` directly.
- The FSM has four states, with `cnt` as a CNT_W-bit counter:
  - **STABLE_LOW** (`signal_out`=0): if `s`=1, go to WAIT_HIGH and set `cnt`<=1; otherwise stay.
  - **WAIT_HIGH**:
    - If `s`=0, return to STABLE_LOW and pulse `glitch`; `signal_out` stays 0.
    - Else if `cnt`==`STABLE_CYCLES`-1, go to STABLE_HIGH and set `signal_out`<=1 on the same edge.
    - Else `cnt`<=`cnt`+1.
  - **STABLE_HIGH** (`signal_out`=1): if `s`=0, go to WAIT_LOW and set `cnt`<=1.
  - **WAIT_LOW**: mirror image of WAIT_HIGH.
    - If `s`=1, return to STABLE_HIGH and pulse `glitch`.
    - Else if `cnt`==`STABLE_CYCLES`-1, go to STABLE_LOW and set `signal_out`<=0.
    - Else increment `cnt`.
  - Illegal state encoding: go to STABLE_LOW with `signal_out`<=0.
- Counter and width rules:
  - `cnt` never exceeds `STABLE_CYCLES`-1, so it never wraps.
  - `cnt` is cleared to 0 in both STABLE states.
- `glitch` is 0 on every edge except an abort edge. Back-to-back aborts, i.e. every other cycle toggling, produce one pulse per abort.
- `signal_out` changes only on a commit edge. Input bounces shorter than `STABLE_CYCLES` samples never reach `signal_out`.

## Timing
- Reset values while `rst_n`=0:
  - state = STABLE_LOW
  - `signal_out`=0, `busy`=0, `glitch`=0
  - `cnt`=0
  - synchronizer flops = 0
- Reset deassertion mid-qualification discards the candidate; operation restarts from STABLE_LOW.
- If `signal_in` is high when reset is released, it is qualified as a normal rising transition. The downstream edge detector will then see one edge; this is intended.
- Latency, with `signal_in` changing before edge k and then held:
  - Without synchronizer: `signal_out` updates at edge k+`STABLE_CYCLES`-1.
  - With synchronizer: `signal_out` updates at edge k+`STABLE_CYCLES`+1.
- `busy` rises the cycle after the entry edge and falls the cycle after the commit or abort edge.
- Disagreeing sample on the commit edge: abort takes priority; no commit occurs.

## Configuration
- Macro: `DEBOUNCE_SYNC_EN`.
- Defined: a two-flop synchronizer (both flops reset to 0) feeds `s`. This adds 2 cycles of latency and makes asynchronous `signal_in` safe.
- Undefined: `s` = `signal_in` with no extra flops. Only legal when `signal_in` is already synchronous to `clk`.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `CNT_W`=5, with `DEBOUNCE_SYNC_EN` defined unless noted.
- **Clean rise:** reset, then `signal_in` 0->1 before edge 10, held high.
  - `signal_out` rises at edge 15.
  - `busy` is high after edges 12..14 only.
  - `glitch` never pulses.
- **Short bounce:** `signal_in` high for 2 cycles, then low.
  - `signal_out` stays 0.
  - Exactly one `glitch` pulse, occurring the edge after `s` returns to 0.
- **Clean fall:** from STABLE_HIGH, `signal_in` 1->0 held.
  - `signal_out` falls exactly 5 edges after the change.
  - Then toggle `signal_in` every cycle for 20 cycles: `signal_out` is unchanged and `glitch` pulses repeatedly.
- **Reset mid-qualification:** assert `rst_n`=0 asynchronously between edges while in WAIT_HIGH.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release with `signal_in` held high, `signal_out` rises 5 edges after the first post-reset edge.
- **Synchronizer compiled out** (`DEBOUNCE_SYNC_EN` undefined): `signal_in` rises before edge 10 and is held.
  - `signal_out` rises at edge 13.
- **Chained with the edge detector:** `signal_in` is a bouncy press.
  - Exactly one `edge_out` pulse per qualified rise; zero pulses for bounces.

Source files
------------

// File: rtl/debounce_fsm.sv
// Debouncer for a raw level input: a level change is committed to signal_out only after
// STABLE_CYCLES consecutive agreeing samples. Define DEBOUNCE_SYNC_EN to add a 2-flop input synchronizer.
module debounce_fsm #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic signal_in,
    output logic signal_out,
    output logic busy,
    output logic glitch
);

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        WAIT_HIGH = 2'b01,
        ST_HIGH   = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_out, w_out_nxt;
    logic             r_glitch, w_glitch_nxt;
    logic             w_s;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync1, r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= signal_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = signal_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_LOW;
            r_cnt    <= '0;
            r_out    <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    // A disagreeing sample is tested before the count, so an abort wins over a commit.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_out_nxt    = r_out;
        w_glitch_nxt = 1'b0;
        case (r_state)
            ST_LOW: begin
                w_cnt_nxt = '0;
                w_out_nxt = 1'b0;
                if (w_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = ONE;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt  = ST_LOW;
                    w_cnt_nxt    = '0;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            ST_HIGH: begin
                w_cnt_nxt = '0;
                w_out_nxt = 1'b1;
                if (!w_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = ONE;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt  = ST_HIGH;
                    w_cnt_nxt    = '0;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
                w_out_nxt   = 1'b0;
            end
        endcase
    end

    assign signal_out = r_out;
    assign glitch     = r_glitch;
    assign busy       = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm (STABLE_CYCLES=4); timing adapts to whether DEBOUNCE_SYNC_EN is defined.
module tb_debounce_fsm;

    localparam int SC = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int E = 2;
`else
    localparam int E = 0;
`endif
    // E = edges from an input change to FSM entry; LAT = edges from change to commit.
    localparam int LAT = SC - 1 + E;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic signal_in = 1'b0;
    logic signal_out, busy, glitch;

    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    int   glitches = 0;
    logic ed_prev = 1'b0;

    always #5 clk = ~clk;

    debounce_fsm #(.STABLE_CYCLES(SC), .CNT_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .signal_in(signal_in),
        .signal_out(signal_out),
        .busy(busy),
        .glitch(glitch)
    );

    // Downstream rising-edge detector model plus glitch pulse counter.
    always @(posedge clk) begin
        if (signal_out && !ed_prev) edges++;
        if (glitch) glitches++;
        ed_prev <= signal_out;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive lvl before edge k and check out/busy/glitch after each of edges k..k+LAT+1.
    task automatic qualify(input string tag, input logic lvl);
        signal_in = lvl;
        for (int j = 1; j <= LAT + 2; j++) begin
            tick();
            chk({tag, "_out"}, signal_out, (j - 1 >= LAT) ? lvl : !lvl);
            chk({tag, "_busy"}, busy, (j - 1 >= E) && (j - 1 < LAT));
            chk({tag, "_glitch"}, glitch, 1'b0);
        end
    endtask

    initial begin
        int g0, e0;
        int press[7];
        int rel[6];
        press = '{1, 0, 1, 1, 0, 1, 0};
        rel   = '{0, 1, 0, 1, 1, 0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", signal_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_glitch", glitch, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_out", signal_out, 1'b0);

        qualify("rise", 1'b1);
        qualify("fall", 1'b0);

        // Two-sample bounce: one glitch pulse, output untouched
        signal_in = 1'b1;
        for (int j = 1; j <= E + 6; j++) begin
            if (j == 3) signal_in = 1'b0;
            tick();
            chk("bounce_glitch", glitch, (j - 1) == (E + 2));
            chk("bounce_out", signal_out, 1'b0);
            chk("bounce_busy", busy, (j - 1) >= E && (j - 1) < E + 2);
        end

        // Toggle every cycle: ten entries, ten aborts, no commit
        g0 = glitches;
        for (int t = 0; t < 20; t++) begin
            signal_in = (t % 2 == 0);
            tick();
            chk("toggle_out", signal_out, 1'b0);
        end
        repeat (E + 3) tick();
        chk("toggle_out_end", signal_out, 1'b0);
        chki("toggle_glitches", glitches - g0, 10);
        repeat (LAT + 2) tick();

        // Asynchronous reset while qualifying a rise
        signal_in = 1'b1;
        repeat (E + 1) tick();
        chk("midq_busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midq_rst_busy", busy, 1'b0);
        chk("midq_rst_out", signal_out, 1'b0);
        chk("midq_rst_glitch", glitch, 1'b0);
        tick();
        tick();
        chk("midq_held_busy", busy, 1'b0);
        #2 rst_n = 1'b1;
        qualify("postrst_rise", 1'b1);

        // Asynchronous reset from STABLE_HIGH clears the output at once
        #2 rst_n = 1'b0;
        #1;
        chk("hi_rst_out", signal_out, 1'b0);
        tick();
        signal_in = 1'b0;
        #2 rst_n = 1'b1;
        repeat (E + 2) tick();
        chk("hi_rst_after_out", signal_out, 1'b0);
        chk("hi_rst_after_busy", busy, 1'b0);

        // Bouncy press into the edge detector: exactly one edge
        e0 = edges;
        foreach (press[i]) begin
            signal_in = press[i][0];
            tick();
        end
        repeat (E + 2) tick();
        chki("chain_bounce_edges", edges - e0, 0);
        chk("chain_bounce_out", signal_out, 1'b0);
        signal_in = 1'b1;
        repeat (LAT + 3) tick();
        chk("chain_press_out", signal_out, 1'b1);
        chki("chain_press_edges", edges - e0, 1);
        foreach (rel[i]) begin
            signal_in = rel[i][0];
            tick();
        end
        repeat (LAT + 3) tick();
        chk("chain_release_out", signal_out, 1'b0);
        chki("chain_release_edges", edges - e0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
